// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner for a shared 2:1 mux with a per-owner hold limit and a valid/ready output.
// Optional grant counters (cnt0/cnt1) are built when MUX_ARB_CNT_EN is defined.
`timescale 1ns/1ps

module mux2_rr_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] d0,
   input  logic             req1,
   input  logic [WIDTH-1:0] d1,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   output logic             gnt0,
   output logic             gnt1,
   output logic             s,
   output logic             busy
`ifdef MUX_ARB_CNT_EN
   ,
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1
`endif
);

   localparam int BEATS_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   // The counter parks at MAX_HOLD-1, so a long solo burst still switches on the next beat.
   localparam logic [BEATS_W-1:0] BEATS_SAT =
      (MAX_HOLD > 0) ? BEATS_W'(MAX_HOLD - 1) : {BEATS_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               s_nxt;
   logic               last, last_nxt;
   logic [BEATS_W-1:0] beats, beats_nxt;

   logic transfer;
   logic hold_hit;
   logic take;
   logic take_owner;

   assign y        = s ? d1 : d0;
   assign y_valid  = ((state == OWN0) && req0) || ((state == OWN1) && req1);
   assign transfer = y_valid && out_ready;
   assign gnt0     = transfer && (state == OWN0);
   assign gnt1     = transfer && (state == OWN1);
   assign busy     = (state != IDLE);
   assign hold_hit = (MAX_HOLD != 0) && transfer && (beats == BEATS_SAT);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
      state_nxt  = state;
      s_nxt      = s;
      last_nxt   = last;
      beats_nxt  = beats;
      take       = 1'b0;
      take_owner = 1'b0;

      unique case (state)
         IDLE: begin
            if (req0 && req1) begin
               take       = 1'b1;
               take_owner = ~last;
            end else if (req0 || req1) begin
               take       = 1'b1;
               take_owner = req1;
            end
         end
         OWN0: begin
            if (!req0) begin
               if (req1) begin
                  take       = 1'b1;
                  take_owner = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (hold_hit && req1) begin
               take       = 1'b1;
               take_owner = 1'b1;
            end else if (transfer && (beats != BEATS_SAT)) begin
               beats_nxt = beats + 1'b1;
            end
         end
         OWN1: begin
            if (!req1) begin
               if (req0) begin
                  take       = 1'b1;
                  take_owner = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (hold_hit && req0) begin
               take       = 1'b1;
               take_owner = 1'b0;
            end else if (transfer && (beats != BEATS_SAT)) begin
               beats_nxt = beats + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A new owner always restarts its burst count and becomes the round-robin reference.
      if (take) begin
         state_nxt = take_owner ? OWN1 : OWN0;
         s_nxt     = take_owner;
         last_nxt  = take_owner;
         beats_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge only; rst_n is not in the sensitivity list.
      if (!rst_n) begin
         state <= IDLE;
         s     <= 1'b0;
         last  <= 1'b1;
         beats <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
         state <= state_nxt;
         s     <= s_nxt;
         last  <= last_nxt;
         beats <= beats_nxt;
      end
   end

`ifdef MUX_ARB_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (gnt0) cnt0 <= cnt0 + 16'd1;
         if (gnt1) cnt1 <= cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Testbench for mux2_rr_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of ownership, round-robin choice and hold limit.
`timescale 1ns/1ps

module tb_mux2_rr_arbiter;

   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req0 = 1'b0;
   logic [WIDTH-1:0] d0 = '0;
   logic             req1 = 1'b0;
   logic [WIDTH-1:0] d1 = '0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] y;
   logic             y_valid, gnt0, gnt1, s, busy;
`ifdef MUX_ARB_CNT_EN
   logic [15:0]      cnt0, cnt1;
`endif

   int passed = 0;
   int total  = 0;

   // Model state: who owns the channel (-1 = nobody), who was served last,
   // which input the mux points at, and how many beats the owner has moved.
   int   m_owner;
   int   m_last;
   logic m_sel;
   int   m_streak;

   mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .d0        (d0),
      .req1      (req1),
      .d1        (d1),
      .out_ready (out_ready),
      .y         (y),
      .y_valid   (y_valid),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .s         (s),
      .busy      (busy)
`ifdef MUX_ARB_CNT_EN
      ,
      .cnt0      (cnt0),
      .cnt1      (cnt1)
`endif
   );

   always #5 clk = ~clk;

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      next_edge();
      rst_n = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      out_ready = 1'b0;
      next_edge();
      rst_n = 1'b1;
      m_owner  = -1;
      m_last   = 1;
      m_sel    = 1'b0;
      m_streak = 0;
   endtask

   // Expected outputs for the current cycle from the model and the inputs now applied.
   task automatic model_eval(output logic ev, output logic eg0, output logic eg1,
                             output logic es, output logic eb, output logic [WIDTH-1:0] ey);
      logic own_req;
      own_req = (m_owner == 0) ? req0 : req1;
      ev  = (m_owner >= 0) && own_req;
      eg0 = ev && out_ready && (m_owner == 0);
      eg1 = ev && out_ready && (m_owner == 1);
      es  = m_sel;
      eb  = (m_owner >= 0);
      ey  = m_sel ? d1 : d0;
   endtask

   task automatic model_claim(input int who);
      m_owner  = who;
      m_last   = who;
      m_sel    = (who == 1);
      m_streak = 0;
   endtask

   task automatic model_advance();
      logic r[2];
      int   other;
      r[0] = req0;
      r[1] = req1;
      if (m_owner < 0) begin
         if (r[0] && r[1]) model_claim(1 - m_last);
         else if (r[0])    model_claim(0);
         else if (r[1])    model_claim(1);
      end else begin
         other = 1 - m_owner;
         if (!r[m_owner]) begin
            if (r[other]) model_claim(other);
            else          m_owner = -1;
         end else if (out_ready) begin
            m_streak++;
            if (MAX_HOLD != 0 && m_streak >= MAX_HOLD && r[other]) model_claim(other);
         end
      end
   endtask

   task automatic test_reset();
      next_edge();
      rst_n = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      out_ready = 1'b1;
      next_edge();
      settle();
      total++;
      if ({y_valid, gnt0, gnt1, busy, s} !== 5'b00000)
         $display("FAIL reset_outputs: got %b expected 00000", {y_valid, gnt0, gnt1, busy, s});
      else passed++;
      rst_n = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic test_single_req();
      do_reset();
      req0 = 1'b1;
      d0 = 8'hA5;
      out_ready = 1'b1;
      settle();
      total++;
      if (y_valid !== 1'b0) $display("FAIL single_latency: y_valid got %b expected 0", y_valid);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         next_edge();
         settle();
         total++;
         if ({s, y_valid, gnt0, gnt1} !== 4'b0110 || y !== 8'hA5)
            $display("FAIL single_beat%0d: s/v/g0/g1 got %b y %h expected 0110 y a5",
                     i, {s, y_valid, gnt0, gnt1}, y);
         else passed++;
      end
   endtask

   task automatic test_hold_limit();
      logic own;
      do_reset();
      req0 = 1'b1;
      req1 = 1'b1;
      d0 = 8'h11;
      d1 = 8'h22;
      out_ready = 1'b1;
      settle();
      total++;
      if (busy !== 1'b0) $display("FAIL hold_idle: busy got %b expected 0", busy);
      else passed++;
      for (int round = 0; round < 3; round++) begin
         own = (round % 2) == 1;
         for (int k = 0; k < MAX_HOLD; k++) begin
            next_edge();
            settle();
            total++;
            if ({s, gnt0, gnt1, y_valid} !== {own, ~own, own, 1'b1} || y !== (own ? 8'h22 : 8'h11))
               $display("FAIL hold_r%0d_b%0d: s/g0/g1/v got %b y %h expected %b y %h", round, k,
                        {s, gnt0, gnt1, y_valid}, y, {own, ~own, own, 1'b1}, own ? 8'h22 : 8'h11);
            else passed++;
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      req1 = 1'b1;
      d1 = 8'h5A;
      out_ready = 1'b0;
      settle();
      for (int i = 0; i < 5; i++) begin
         next_edge();
         req0 = 1'b1;
         d0 = 8'h33;
         settle();
         total++;
         if ({y_valid, gnt1, gnt0, s} !== 4'b1001)
            $display("FAIL stall_%0d: v/g1/g0/s got %b expected 1001", i, {y_valid, gnt1, gnt0, s});
         else passed++;
      end
      next_edge();
      out_ready = 1'b1;
      settle();
      total++;
      if (gnt1 !== 1'b1 || y !== 8'h5A)
         $display("FAIL stall_release: gnt1 got %b y %h expected 1 y 5a", gnt1, y);
      else passed++;
   endtask

   task automatic test_abandon();
      // Other side waiting: ownership passes straight over.
      do_reset();
      req0 = 1'b1;
      req1 = 1'b1;
      out_ready = 1'b0;
      settle();
      next_edge();
      settle();
      total++;
      if ({s, y_valid, gnt0} !== 3'b010)
         $display("FAIL abandon_own0: s/v/g0 got %b expected 010", {s, y_valid, gnt0});
      else passed++;
      next_edge();
      req0 = 1'b0;
      out_ready = 1'b1;
      settle();
      total++;
      if ({y_valid, gnt0, gnt1} !== 3'b000)
         $display("FAIL abandon_drop: v/g0/g1 got %b expected 000", {y_valid, gnt0, gnt1});
      else passed++;
      next_edge();
      settle();
      total++;
      if ({s, y_valid, gnt0, gnt1} !== 4'b1101)
         $display("FAIL abandon_switch: s/v/g0/g1 got %b expected 1101", {s, y_valid, gnt0, gnt1});
      else passed++;

      // Nobody waiting: back to IDLE with the select left alone.
      do_reset();
      req0 = 1'b1;
      out_ready = 1'b0;
      settle();
      next_edge();
      settle();
      next_edge();
      req0 = 1'b0;
      out_ready = 1'b1;
      settle();
      next_edge();
      settle();
      total++;
      if ({busy, s, y_valid, gnt0} !== 4'b0000)
         $display("FAIL abandon_idle: busy/s/v/g0 got %b expected 0000", {busy, s, y_valid, gnt0});
      else passed++;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req1 = 1'b1;
      out_ready = 1'b1;
      settle();
      repeat (3) begin
         next_edge();
         settle();
      end
      next_edge();
      rst_n = 1'b0;
      settle();
      next_edge();
      rst_n = 1'b1;
      req0 = 1'b1;
      req1 = 1'b1;
      settle();
      total++;
      if ({y_valid, s, busy} !== 3'b000)
         $display("FAIL midreset_state: v/s/busy got %b expected 000", {y_valid, s, busy});
      else passed++;
      next_edge();
      settle();
      total++;
      if ({s, gnt0, gnt1} !== 3'b010)
         $display("FAIL midreset_first: s/g0/g1 got %b expected 010", {s, gnt0, gnt1});
      else passed++;
   endtask

   task automatic test_random();
      logic             ev, eg0, eg1, es, eb;
      logic [WIDTH-1:0] ey;
      logic             pg0, pg1;
      do_reset();
      pg0 = 1'b0;
      pg1 = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!req0) begin
            req0 = ($urandom_range(0, 2) != 0);
            d0 = 8'($urandom);
         end else if (pg0) begin
            req0 = ($urandom_range(0, 3) != 0);
            d0 = 8'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            req0 = 1'b0;
         end
         if (!req1) begin
            req1 = ($urandom_range(0, 2) != 0);
            d1 = 8'($urandom);
         end else if (pg1) begin
            req1 = ($urandom_range(0, 3) != 0);
            d1 = 8'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            req1 = 1'b0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         settle();
         model_eval(ev, eg0, eg1, es, eb, ey);
         total++;
         if ({y_valid, gnt0, gnt1, s, busy, y} !== {ev, eg0, eg1, es, eb, ey})
            $display("FAIL random_c%0d: v/g0/g1/s/busy got %b y %h expected %b y %h", cyc,
                     {y_valid, gnt0, gnt1, s, busy}, y, {ev, eg0, eg1, es, eb}, ey);
         else passed++;
         model_advance();
         pg0 = eg0;
         pg1 = eg1;
         next_edge();
      end
   endtask

`ifdef MUX_ARB_CNT_EN
   task automatic test_counters();
      int seen;
      int budget;
      do_reset();
      out_ready = 1'b1;
      req0 = 1'b1;
      seen = 0;
      budget = 0;
      while (seen < 10 && budget < 100) begin
         settle();
         if (gnt0) seen++;
         budget++;
         next_edge();
      end
      req0 = 1'b0;
      req1 = 1'b1;
      seen = 0;
      while (seen < 3 && budget < 200) begin
         settle();
         if (gnt1) seen++;
         budget++;
         next_edge();
      end
      req1 = 1'b0;
      settle();
      total++;
      if (budget >= 200 || cnt0 !== 16'd10 || cnt1 !== 16'd3)
         $display("FAIL cnt_basic: cnt0 %0d cnt1 %0d expected 10 and 3 (budget %0d)", cnt0, cnt1, budget);
      else passed++;

      do_reset();
      out_ready = 1'b1;
      req0 = 1'b1;
      seen = 0;
      budget = 0;
      while (seen < 65535 && budget < 70000) begin
         settle();
         if (gnt0) seen++;
         budget++;
         next_edge();
      end
      settle();
      total++;
      if (cnt0 !== 16'hFFFF) $display("FAIL cnt_full: cnt0 got %h expected ffff", cnt0);
      else passed++;
      next_edge();
      req0 = 1'b0;
      settle();
      total++;
      if (cnt0 !== 16'h0000) $display("FAIL cnt_wrap: cnt0 got %h expected 0000", cnt0);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_req();
      test_hold_limit();
      test_stall();
      test_abandon();
      test_reset_mid_burst();
      test_random();
`ifdef MUX_ARB_CNT_EN
      test_counters();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
